// File: rtl/vga_pkg.sv
// Shared VGA types and constants for the sprite overlay datapath.
package vga_pkg;

  localparam int unsigned CoordW = 10;
  localparam int unsigned ColorW = 12;

  typedef logic [ColorW-1:0] color_t;

  localparam color_t KeyDefault = 12'hFFF;

  // Built-in bitmap used when no init file is given: (0,0) is green, and pixels whose
  // row^col ends in 2'b11 are transparent.
  function automatic color_t rom_pattern(input int unsigned row, input int unsigned col);
    int unsigned v;
    if (((row ^ col) & 32'd3) == 32'd3) begin
      return KeyDefault;
    end
    v = 32'h0F0 + (row << 8) + col;
    return v[ColorW-1:0];
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap ROM with a fixed read latency of ROM_LAT clock cycles.
module sprite_rom
  import vga_pkg::*;
#(
  parameter int unsigned ROW_W     = 4,
  parameter int unsigned COL_W     = 8,
  parameter int unsigned ROM_LAT   = 1,
  parameter string       INIT_FILE = "sprite.mem"
) (
  input  logic             clk,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output color_t           color_data
);

  color_t rd_data;
  color_t pipe_q [ROM_LAT];

  assign rd_data = rom_pattern(32'(row), 32'(col));

  always_ff @(posedge clk) begin
    pipe_q[0] <= rd_data;
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign color_data = pipe_q[ROM_LAT-1];

endmodule

// File: rtl/sprite_overlay_ctrl.sv
// Overlays a ROM sprite on the video stream with frame-synchronous moves and blinking.
module sprite_overlay_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned X0_INIT   = 355,
  parameter int unsigned Y0_INIT   = 277,
  parameter int unsigned W         = 132,
  parameter int unsigned H         = 11,
  parameter int unsigned ROW_W     = 4,
  parameter int unsigned COL_W     = 8,
  parameter int unsigned SCALE_SH  = 0,
  parameter color_t      KEY       = KeyDefault,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned BLINK_FR  = 30,
  parameter string       INIT_FILE = "sprite.mem"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bright,
  input  logic              en,
  input  logic [CoordW-1:0] hCount,
  input  logic [CoordW-1:0] vCount,
  input  color_t            background,
  input  logic [CoordW-1:0] pos_x,
  input  logic [CoordW-1:0] pos_y,
  input  logic              pos_valid,
  output logic              pos_ready,
  input  logic              blink_en,
  output color_t            rgb
);

  localparam int unsigned WinW = W << SCALE_SH;
  localparam int unsigned WinH = H << SCALE_SH;
  localparam int unsigned CntW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  // One extra bit so a window running past column/row 1023 clips instead of wrapping.
  typedef logic [CoordW:0] ext_t;

  logic [CoordW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CoordW-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic              pend_valid_q, pend_valid_d;
  logic              frame_start_q, frame_start_d;
  logic [CntW-1:0]   blink_cnt_q, blink_cnt_d;
  logic              visible_q, visible_d;
  logic [ROM_LAT-1:0] on_q, on_d;

  logic       vis;
  logic       sprite_on;
  ext_t       x_lo, x_hi, y_lo, y_hi, hc, vc;
  logic [ROW_W-1:0] rom_row;
  logic [COL_W-1:0] rom_col;
  color_t     rom_color;

  assign pos_ready = !pend_valid_q;

  always_comb begin
    frame_start_d = (hCount == '0) && (vCount == '0);
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    pend_x_d      = pend_x_q;
    pend_y_d      = pend_y_q;
    pend_valid_d  = pend_valid_q;
    if (frame_start_q && pend_valid_q) begin
      cur_x_d      = pend_x_q;
      cur_y_d      = pend_y_q;
      pend_valid_d = 1'b0;
    end else if (pos_valid && pos_ready) begin
      pend_x_d     = pos_x;
      pend_y_d     = pos_y;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (frame_start_q) begin
      if (blink_cnt_q == CntW'(BLINK_FR - 1)) begin
        blink_cnt_d = '0;
        visible_d   = !visible_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign vis  = visible_q || !blink_en;
  assign hc   = {1'b0, hCount};
  assign vc   = {1'b0, vCount};
  assign x_lo = {1'b0, cur_x_q};
  assign y_lo = {1'b0, cur_y_q};
  assign x_hi = x_lo + ext_t'(WinW);
  assign y_hi = y_lo + ext_t'(WinH);

  assign sprite_on = en && vis && (hc >= x_lo) && (hc < x_hi) && (vc >= y_lo) && (vc < y_hi);
  assign rom_row   = ROW_W'((vCount - cur_y_q) >> SCALE_SH);
  assign rom_col   = COL_W'((hCount - cur_x_q) >> SCALE_SH);

  // Delay the hit flag so it lines up with the ROM output.
  assign on_d = ROM_LAT'({on_q, sprite_on});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x_q       <= CoordW'(X0_INIT);
      cur_y_q       <= CoordW'(Y0_INIT);
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      pend_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      blink_cnt_q   <= '0;
      visible_q     <= 1'b1;
      on_q          <= '0;
    end else begin
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      pend_valid_q  <= pend_valid_d;
      frame_start_q <= frame_start_d;
      blink_cnt_q   <= blink_cnt_d;
      visible_q     <= visible_d;
      on_q          <= on_d;
    end
  end

  sprite_rom #(
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .ROM_LAT   (ROM_LAT),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk        (clk),
    .row        (rom_row),
    .col        (rom_col),
    .color_data (rom_color)
  );

  always_comb begin
    rgb = background;
    if (!bright) begin
      rgb = '0;
    end else if (on_q[ROM_LAT-1] && (rom_color != KEY)) begin
      rgb = rom_color;
    end
  end

endmodule

// File: tb/tb_sprite_overlay_ctrl.sv
// Bench for sprite_overlay_ctrl: a default build and a 2x-scaled, fast-blink, 2-cycle-ROM build.
module tb_sprite_overlay_ctrl;

  logic        clk = 1'b0;
  logic        rst, bright, en, pos_valid, blink_en;
  logic [9:0]  hCount, vCount, pos_x, pos_y;
  logic [11:0] background;
  logic        rdy_a, rdy_b;
  logic [11:0] rgb_a, rgb_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sprite_overlay_ctrl #(
    .INIT_FILE ("")
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bright     (bright),
    .en         (en),
    .hCount     (hCount),
    .vCount     (vCount),
    .background (background),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_valid  (pos_valid),
    .pos_ready  (rdy_a),
    .blink_en   (blink_en),
    .rgb        (rgb_a)
  );

  sprite_overlay_ctrl #(
    .SCALE_SH  (1),
    .BLINK_FR  (2),
    .ROM_LAT   (2),
    .INIT_FILE ("")
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bright     (bright),
    .en         (en),
    .hCount     (hCount),
    .vCount     (vCount),
    .background (background),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_valid  (pos_valid),
    .pos_ready  (rdy_b),
    .blink_en   (blink_en),
    .rgb        (rgb_b)
  );

  // Reference model: per build, sprite position, pending request, frames seen while
  // blinking, and a history of the sprite pixel (or -1) requested on each cycle.
  int cx [2], cy [2], px [2], py [2], nfr [2];
  bit pv [2], fs [2];
  int hist [2][8];
  int cyc = 0;

  function automatic int lat(input int k);  return (k == 0) ? 1 : 2;  endfunction
  function automatic int scl(input int k);  return (k == 0) ? 1 : 2;  endfunction
  function automatic int bfr(input int k);  return (k == 0) ? 30 : 2; endfunction

  function automatic int pat(input int r, input int c);
    if (((r ^ c) & 3) == 3) return 'hFFF;
    return ('h0F0 + r * 256 + c) % 4096;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cx[k] = 355; cy[k] = 277; px[k] = 0; py[k] = 0;
      pv[k] = 1'b0; fs[k] = 1'b0; nfr[k] = 0;
      for (int i = 0; i < 8; i++) hist[k][i] = -1;
    end
  endtask

  function automatic int entry(input int k);
    int  s = scl(k);
    int  h = int'(hCount);
    int  v = int'(vCount);
    bit  vis = !blink_en || (((nfr[k] / bfr(k)) % 2) == 0);
    if (en && vis && h >= cx[k] && h < cx[k] + 132 * s && v >= cy[k] && v < cy[k] + 11 * s)
      return pat((v - cy[k]) / s, (h - cx[k]) / s);
    return -1;
  endfunction

  function automatic int exp_rgb(input int k);
    int e = hist[k][(cyc + 8 - lat(k)) % 8];
    if (!bright) return 0;
    if (e >= 0 && e != 'hFFF) return e;
    return int'(background);
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int  e [2];
    bit  v, hz, be, rdy;
    int  nx, ny;
    #1;
    if (rst) model_reset();
    chk("rgb_a", rgb_a, 12'(exp_rgb(0)));
    chk("rgb_b", rgb_b, 12'(exp_rgb(1)));
    chk("ready_a", {11'b0, rdy_a}, {11'b0, !pv[0]});
    chk("ready_b", {11'b0, rdy_b}, {11'b0, !pv[1]});
    for (int k = 0; k < 2; k++) e[k] = entry(k);
    v  = pos_valid;
    nx = int'(pos_x);
    ny = int'(pos_y);
    hz = (hCount == 10'd0) && (vCount == 10'd0);
    be = blink_en;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        hist[k][cyc % 8] = e[k];
        rdy = !pv[k];
        if (fs[k] && pv[k]) begin
          cx[k] = px[k]; cy[k] = py[k]; pv[k] = 1'b0;
        end
        if (v && rdy) begin
          px[k] = nx; py[k] = ny; pv[k] = 1'b1;
        end
        if (!be) nfr[k] = 0;
        else if (fs[k]) nfr[k]++;
        fs[k] = hz;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic pix(input int h, input int v);
    hCount     = 10'(h);
    vCount     = 10'(v);
    background = 12'($urandom);
    cycle();
  endtask

  function automatic int clamp(input int x);
    if (x < 0) return 0;
    if (x > 1023) return 1023;
    return x;
  endfunction

  initial begin
    rst = 1'b1; bright = 1'b1; en = 1'b1; blink_en = 1'b0;
    hCount = 10'd500; vCount = 10'd500; background = 12'h123;
    pos_x = '0; pos_y = '0; pos_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    pix(500, 500);
    pix(500, 500);
    rst = 1'b0;

    // Home position, KEY transparency, dark blanking
    for (int h = 352; h <= 362; h++) pix(h, 277);
    pix(355, 277);
    chk("req037_a", rgb_a, 12'h0F0);
    pix(358, 277);
    chk("req037_b", rgb_b, 12'h0F0);
    pix(600, 600);
    chk("req037_key", rgb_a, background);
    bright = 1'b0;
    pix(355, 277);
    pix(356, 277);
    chk("dark", rgb_a, 12'h000);
    bright = 1'b1;

    // Window edges of both builds
    pix(486, 280); pix(487, 280); pix(618, 280); pix(619, 280);
    pix(356, 287); pix(356, 288); pix(356, 298); pix(356, 299);

    // Move request mid-frame
    pos_x = 10'd100; pos_y = 10'd50; pos_valid = 1'b1;
    pix(355, 277);
    pos_valid = 1'b0;
    chk("req038_ready_low", {11'b0, rdy_a}, 12'h000);
    pix(100, 50); pix(355, 277); pix(101, 50);
    pix(0, 0);
    pix(356, 277);
    chk("req038_ready_high", {11'b0, rdy_a}, 12'h001);
    pix(100, 50);
    chk("req038_new", rgb_a, 12'h0F0);
    pix(355, 277);
    chk("req038_old_gone", rgb_a, background);

    // Request landing in the frame_start cycle waits a whole frame
    pix(0, 0);
    pos_x = 10'd200; pos_y = 10'd100; pos_valid = 1'b1;
    pix(600, 600);
    pos_valid = 1'b0;
    pix(200, 100);
    chk("req025_not_yet", rgb_a, background);
    pix(100, 50);
    chk("req025_old", rgb_a, 12'h0F0);
    pix(0, 0); pix(600, 600); pix(200, 100);
    chk("req025_applied", rgb_a, 12'h0F0);

    // Right-edge clipping
    pos_x = 10'd1000; pos_y = 10'd10; pos_valid = 1'b1;
    pix(600, 600);
    pos_valid = 1'b0;
    pix(0, 0); pix(600, 600);
    for (int h = 995; h <= 1023; h++) pix(h, 11);
    for (int h = 0; h <= 3; h++) pix(h, 11);
    pix(1023, 11);
    chk("req041_last", rgb_a, 12'h207);
    pix(0, 11);
    chk("req041_nowrap", rgb_a, background);
    pix(1000, 10);
    chk("req041_first", rgb_a, 12'h0F0);

    // Blinking over six frames, then release
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pix(0, 0);
      for (int j = 0; j < 4; j++) pix(1000 + j, 10 + j);
    end
    pix(1000, 10); pix(1001, 10);
    chk("req040_hidden", rgb_b, background);
    blink_en = 1'b0;
    pix(1000, 10); pix(1001, 10);
    chk("req040_restore", rgb_b, 12'h0F0);

    // Enable drop drains through the pipeline
    en = 1'b0;
    pix(1000, 10); pix(1001, 10); pix(1002, 10);
    en = 1'b1;

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      int k;
      bright    = ($urandom_range(0, 9) != 0);
      en        = ($urandom_range(0, 15) != 0);
      pos_valid = ($urandom_range(0, 7) == 0);
      pos_x     = 10'($urandom_range(0, 1023));
      pos_y     = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 49) == 0) blink_en = !blink_en;
      if ($urandom_range(0, 99) < 5) begin
        pix(0, 0);
      end else begin
        k = int'($urandom_range(0, 1));
        pix(clamp(cx[k] + int'($urandom_range(0, 280)) - 8),
            clamp(cy[k] + int'($urandom_range(0, 25)) - 2));
      end
    end

    // Asynchronous reset in the middle of the sprite
    pos_valid = 1'b0; blink_en = 1'b0; en = 1'b1; bright = 1'b1;
    pix(cx[0], cy[0]);
    chk("req042_pre", rgb_a, 12'h0F0);
    rst = 1'b1;
    #2;
    chk("req042_bg", rgb_a, background);
    pix(cx[0], cy[0]);
    rst = 1'b0;
    pix(355, 277);
    chk("req042_home", rgb_a, 12'h0F0);
    pix(356, 277);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
